rv32_pc_sequencer: RTL and testbench
====================================

Name: rv32_pc_sequencer

Overview:
- Per-hart program-counter controller for the barrel-threaded rv32 core.
- Holds one PC per hart and picks the next hart to fetch, round-robin.
- Issues fetch requests over a valid/ready handshake.
- Updates each hart's PC from the commit-stage next-PC result (redirect flag + target).
- Halts harts on misaligned redirect targets.

Parameters:
- NUM_HARTS, 8, number of hardware threads; power of two, ≥2.
- XPR_LEN, 32, PC width.
- RESET_PC, 32'h0000_0000, PC loaded into every hart on reset.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- hart_en  input  NUM_HARTS  per-hart run enable
- fetch_valid  output  1  fetch request valid
- fetch_ready  input  1  fetch stage accepts request
- fetch_hart  output  $clog2(NUM_HARTS)  hart id of request
- fetch_pc  output  XPR_LEN  PC to fetch
- commit_valid  input  1  an instruction retired this cycle
- commit_hart  input  $clog2(NUM_HARTS)  hart id of retiring instruction
- commit_has_new_pc  input  1  redirect flag from next-PC unit
- commit_next_pc  input  XPR_LEN  redirect target
- misalign_err  output  1  one-cycle pulse: misaligned redirect
- misalign_hart  output  $clog2(NUM_HARTS)  faulting hart
- misalign_pc  output  XPR_LEN  PC of faulting instruction
- hart_busy  output  NUM_HARTS  hart has an instruction in flight

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. On rst:
  - all PCs = RESET_PC; all hart states = HALT; error stickies cleared; rr_ptr = 0.
  - fetch_valid = 0, fetch_hart = 0, fetch_pc = 0.
  - misalign_err = 0, misalign_hart = 0, misalign_pc = 0, hart_busy = 0.
  - rst mid-operation discards in-flight state; commits that arrive in the reset cycle are ignored.
- Per-hart FSM, states HALT / RUN / WAIT:
  - HALT→RUN when hart_en=1 and the sticky error bit is 0. The PC is retained; no reload.
  - RUN→HALT when hart_en=0.
  - RUN→WAIT when this hart's request is accepted (fetch_valid & fetch_ready).
  - WAIT→RUN on a commit for this hart with a legal result, if hart_en=1.
  - WAIT→HALT on such a commit if hart_en=0; hart_en dropping while in WAIT does not abort the in-flight instruction.
  - WAIT→HALT with sticky error set on a misaligned commit.
  - The sticky error clears only while hart_en=0.
- Commit handling, for commit_valid with commit_hart in WAIT:
  - has_new_pc=0: PC <= PC+4, modulo 2^XPR_LEN (wraps).
  - has_new_pc=1 and commit_next_pc[1:0]==0: PC <= commit_next_pc.
  - has_new_pc=1 and commit_next_pc[1:0]!=0:
    - PC is unchanged.
    - Next cycle: misalign_err=1, misalign_hart=commit_hart, misalign_pc=the old PC.
    - misalign_hart and misalign_pc hold until the next error.
  - A commit for a hart not in WAIT is ignored, with no state change.
- Selection and issue:
  - When no request is pending, or the pending request is accepted this cycle, choose the first hart in RUN scanning rr_ptr, rr_ptr+1, … (mod NUM_HARTS).
  - Selection uses current-cycle state. A hart committing in cycle t is not eligible until t+1.
  - The chosen hart is registered into fetch_valid/fetch_hart/fetch_pc, visible the next cycle.
  - On acceptance: hart→WAIT and rr_ptr <= fetch_hart+1 (wraps).
  - With fetch_ready held at 1 and ≥2 harts runnable, one request is issued per cycle (back-to-back).
- Handshake:
  - Once fetch_valid=1, fetch_hart and fetch_pc are stable until fetch_ready=1.
  - If the pending hart's hart_en drops, the request is still held until accepted (no retraction).
  - fetch_valid=0 when no hart is in RUN.
- hart_busy[i] = (state[i]==WAIT), registered.

Test Plan:
- Reset, then all hart_en=1, fetch_ready=1, no commits → requests for harts 0..7 on consecutive cycles, all fetch_pc=0, then fetch_valid=0; hart_busy=8'hFF.
- Hart 2 commits has_new_pc=0, then hart 3 commits has_new_pc=1 with next_pc=0x100 → next fetches: hart 2 pc=0x4, hart 3 pc=0x100, in round-robin order from rr_ptr.
- fetch_ready=0 for 5 cycles with fetch_valid=1 for hart 1 → fetch_hart=1 and fetch_pc stable for all 5 cycles; no other hart enters WAIT; hart 1 enters WAIT the cycle after ready rises.
- Hart 4 commits has_new_pc=1, next_pc=0x102 → misalign_err pulses 1 cycle, misalign_hart=4, misalign_pc=hart 4's old PC; hart 4 stays HALT until hart_en[4] goes 0 then 1; its PC is still the old value.
- Only hart 0 enabled, PC=0xFFFF_FFFC, commit has_new_pc=0 → next fetch_pc=0x0 (wrap). Commit for hart 0 in the same cycle it would be selected → reissue occurs one cycle later.
- hart_en[5]=0 while hart 5 is in WAIT → its commit updates PC, hart goes to HALT, no further hart 5 fetches. Assert rst mid-burst → all outputs 0 the next cycle; a commit in the reset cycle is ignored.

Source files
------------

// File: rtl/rv32_pc_sequencer.sv
// Per-hart PC sequencer for the barrel-threaded rv32 core: round-robin fetch issue,
// commit-driven PC update and misaligned-redirect halting.
module rv32_pc_sequencer #(
    parameter int                   NUM_HARTS = 8,
    parameter int                   XPR_LEN   = 32,
    parameter logic [XPR_LEN-1:0]   RESET_PC  = {XPR_LEN{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_HARTS-1:0]          hart_en,
    output logic                          fetch_valid,
    input  logic                          fetch_ready,
    output logic [$clog2(NUM_HARTS)-1:0]  fetch_hart,
    output logic [XPR_LEN-1:0]            fetch_pc,
    input  logic                          commit_valid,
    input  logic [$clog2(NUM_HARTS)-1:0]  commit_hart,
    input  logic                          commit_has_new_pc,
    input  logic [XPR_LEN-1:0]            commit_next_pc,
    output logic                          misalign_err,
    output logic [$clog2(NUM_HARTS)-1:0]  misalign_hart,
    output logic [XPR_LEN-1:0]            misalign_pc,
    output logic [NUM_HARTS-1:0]          hart_busy
);

    localparam int                 HW        = $clog2(NUM_HARTS);
    localparam logic [HW-1:0]      HART_ONE  = HW'(1);
    localparam logic [XPR_LEN-1:0] PC_STEP   = XPR_LEN'(4);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } hart_state_e;

    hart_state_e          state_q [NUM_HARTS];
    hart_state_e          state_d [NUM_HARTS];
    logic [XPR_LEN-1:0]   pc_q    [NUM_HARTS];
    logic [XPR_LEN-1:0]   pc_d    [NUM_HARTS];
    logic [NUM_HARTS-1:0] err_q, err_d;
    logic [HW-1:0]        rr_ptr_q, rr_ptr_d;

    logic                 fetch_valid_q, fetch_valid_d;
    logic [HW-1:0]        fetch_hart_q, fetch_hart_d;
    logic [XPR_LEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic                 misalign_err_q, misalign_err_d;
    logic [HW-1:0]        misalign_hart_q, misalign_hart_d;
    logic [XPR_LEN-1:0]   misalign_pc_q, misalign_pc_d;
    logic [NUM_HARTS-1:0] hart_busy_q, hart_busy_d;

    logic                 accept_s;
    logic                 commit_live_s;
    logic                 commit_bad_s;
    logic [HW-1:0]        scan_base_s;
    logic [HW-1:0]        scan_idx_s;
    logic                 sel_found_s;
    logic [HW-1:0]        sel_hart_s;
    logic                 this_commit_s;

    // Next-state logic: hart FSMs, PC updates, round-robin selection, output staging.
    always_comb begin
        accept_s      = fetch_valid_q && fetch_ready;
        commit_live_s = commit_valid && (state_q[commit_hart] == ST_WAIT);
        commit_bad_s  = commit_live_s && commit_has_new_pc && (commit_next_pc[1:0] != 2'b00);

        // After an accept the scan restarts just past the granted hart, which is excluded.
        if (accept_s) begin
            scan_base_s = fetch_hart_q + HART_ONE;
        end else begin
            scan_base_s = rr_ptr_q;
        end
        sel_found_s = 1'b0;
        sel_hart_s  = '0;
        scan_idx_s  = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            scan_idx_s = scan_base_s + HW'(k);
            if (!sel_found_s && (state_q[scan_idx_s] == ST_RUN) && hart_en[scan_idx_s] &&
                !(fetch_valid_q && (scan_idx_s == fetch_hart_q))) begin
                sel_found_s = 1'b1;
                sel_hart_s  = scan_idx_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end

        this_commit_s = 1'b0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            state_d[i]    = state_q[i];
            pc_d[i]       = pc_q[i];
            err_d[i]      = err_q[i];
            this_commit_s = commit_live_s && (commit_hart == HW'(i));
            case (state_q[i])
                ST_HALT: begin
                    if (hart_en[i] && !err_q[i]) begin
                        state_d[i] = ST_RUN;
                    end else begin
                        state_d[i] = ST_HALT;
                    end
                end
                ST_RUN: begin
                    // A posted request is never retracted, even if the hart is disabled meanwhile.
                    if (accept_s && (fetch_hart_q == HW'(i))) begin
                        state_d[i] = ST_WAIT;
                    end else if (fetch_valid_q && (fetch_hart_q == HW'(i))) begin
                        state_d[i] = ST_RUN;
                    end else if (!hart_en[i]) begin
                        state_d[i] = ST_HALT;
                    end else begin
                        state_d[i] = ST_RUN;
                    end
                end
                ST_WAIT: begin
                    if (this_commit_s && commit_bad_s) begin
                        state_d[i] = ST_HALT;
                        err_d[i]   = 1'b1;
                    end else if (this_commit_s) begin
                        if (commit_has_new_pc) begin
                            pc_d[i] = commit_next_pc;
                        end else begin
                            pc_d[i] = pc_q[i] + PC_STEP;
                        end
                        state_d[i] = hart_en[i] ? ST_RUN : ST_HALT;
                    end else begin
                        state_d[i] = ST_WAIT;
                    end
                end
                default: begin
                    state_d[i] = ST_HALT;
                end
            endcase
            if (!hart_en[i] && !(this_commit_s && commit_bad_s)) begin
                err_d[i] = 1'b0;
            end else begin
                err_d[i] = err_d[i];
            end
            hart_busy_d[i] = (state_d[i] == ST_WAIT);
        end

        if (accept_s) begin
            rr_ptr_d = fetch_hart_q + HART_ONE;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        if (fetch_valid_q && !fetch_ready) begin
            fetch_valid_d = fetch_valid_q;
            fetch_hart_d  = fetch_hart_q;
            fetch_pc_d    = fetch_pc_q;
        end else if (sel_found_s) begin
            fetch_valid_d = 1'b1;
            fetch_hart_d  = sel_hart_s;
            fetch_pc_d    = pc_q[sel_hart_s];
        end else begin
            fetch_valid_d = 1'b0;
            fetch_hart_d  = '0;
            fetch_pc_d    = '0;
        end

        misalign_err_d = commit_bad_s;
        if (commit_bad_s) begin
            misalign_hart_d = commit_hart;
            misalign_pc_d   = pc_q[commit_hart];
        end else begin
            misalign_hart_d = misalign_hart_q;
            misalign_pc_d   = misalign_pc_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                state_q[i] <= ST_HALT;
                pc_q[i]    <= RESET_PC;
            end
            err_q           <= '0;
            rr_ptr_q        <= '0;
            fetch_valid_q   <= 1'b0;
            fetch_hart_q    <= '0;
            fetch_pc_q      <= '0;
            misalign_err_q  <= 1'b0;
            misalign_hart_q <= '0;
            misalign_pc_q   <= '0;
            hart_busy_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                state_q[i] <= state_d[i];
                pc_q[i]    <= pc_d[i];
            end
            err_q           <= err_d;
            rr_ptr_q        <= rr_ptr_d;
            fetch_valid_q   <= fetch_valid_d;
            fetch_hart_q    <= fetch_hart_d;
            fetch_pc_q      <= fetch_pc_d;
            misalign_err_q  <= misalign_err_d;
            misalign_hart_q <= misalign_hart_d;
            misalign_pc_q   <= misalign_pc_d;
            hart_busy_q     <= hart_busy_d;
        end
    end

    assign fetch_valid   = fetch_valid_q;
    assign fetch_hart    = fetch_hart_q;
    assign fetch_pc      = fetch_pc_q;
    assign misalign_err  = misalign_err_q;
    assign misalign_hart = misalign_hart_q;
    assign misalign_pc   = misalign_pc_q;
    assign hart_busy     = hart_busy_q;

endmodule

// File: tb/tb_rv32_pc_sequencer.sv
// Directed bench for rv32_pc_sequencer: round-robin issue, commit updates, stall,
// misalignment halt, PC wrap, hart disable while in flight and mid-burst reset.
module tb_rv32_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  hart_en;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [2:0]  fetch_hart;
    logic [31:0] fetch_pc;
    logic        commit_valid;
    logic [2:0]  commit_hart;
    logic        commit_has_new_pc;
    logic [31:0] commit_next_pc;
    logic        misalign_err;
    logic [2:0]  misalign_hart;
    logic [31:0] misalign_pc;
    logic [7:0]  hart_busy;

    int checks = 0;
    int errors = 0;

    rv32_pc_sequencer #(.NUM_HARTS(8), .XPR_LEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .hart_en(hart_en),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_hart(fetch_hart), .fetch_pc(fetch_pc),
        .commit_valid(commit_valid), .commit_hart(commit_hart),
        .commit_has_new_pc(commit_has_new_pc), .commit_next_pc(commit_next_pc),
        .misalign_err(misalign_err), .misalign_hart(misalign_hart),
        .misalign_pc(misalign_pc), .hart_busy(hart_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_commit(input logic v, input logic [2:0] h, input logic np, input logic [31:0] pc);
        commit_valid      = v;
        commit_hart       = h;
        commit_has_new_pc = np;
        commit_next_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1; hart_en = 8'h00; fetch_ready = 1'b0;
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        tick(); tick();
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc, misalign_err, misalign_hart, misalign_pc, hart_busy} !== 80'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b h=%0d pc=%h me=%b mh=%0d mpc=%h busy=%h, expected all zero",
                     fetch_valid, fetch_hart, fetch_pc, misalign_err, misalign_hart, misalign_pc, hart_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        hart_en = 8'hFF; fetch_ready = 1'b1;
        tick();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL rr_first_idle: got valid=%b expected 0", fetch_valid);
        end
        for (int h = 0; h < 8; h++) begin
            tick();
            checks++;
            if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 3'(h), 32'h0}) begin
                errors++;
                $display("FAIL rr_issue%0d: got v=%b h=%0d pc=%h expected v=1 h=%0d pc=0",
                         h, fetch_valid, fetch_hart, fetch_pc, h);
            end
        end
        tick();
        checks++;
        if ({fetch_valid, hart_busy} !== {1'b0, 8'hFF}) begin
            errors++; $display("FAIL rr_all_busy: got v=%b busy=%h expected v=0 busy=ff", fetch_valid, hart_busy);
        end
    endtask

    task automatic test_commit_update();
        set_commit(1'b1, 3'd2, 1'b0, 32'h0);
        tick();
        set_commit(1'b1, 3'd3, 1'b1, 32'h0000_0100);
        tick();
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 3'd2, 32'h4}) begin
            errors++; $display("FAIL commit_seq_h2: got v=%b h=%0d pc=%h expected v=1 h=2 pc=4", fetch_valid, fetch_hart, fetch_pc);
        end
        tick();
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 3'd3, 32'h100}) begin
            errors++; $display("FAIL commit_redir_h3: got v=%b h=%0d pc=%h expected v=1 h=3 pc=100", fetch_valid, fetch_hart, fetch_pc);
        end
        tick();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL commit_drain: got valid=%b expected 0", fetch_valid);
        end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        set_commit(1'b1, 3'd1, 1'b0, 32'h0);
        tick();
        set_commit(1'b1, 3'd6, 1'b0, 32'h0);
        tick();
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({fetch_valid, fetch_hart, fetch_pc, hart_busy[1], hart_busy[6]} !== {1'b1, 3'd1, 32'h4, 2'b00}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b h=%0d pc=%h busy=%h expected v=1 h=1 pc=4 busy[1]=0 busy[6]=0",
                         k, fetch_valid, fetch_hart, fetch_pc, hart_busy);
            end
            if (k < 4) tick();
        end
        fetch_ready = 1'b1;
        tick();
        checks++;
        if ({hart_busy[1], fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 1'b1, 3'd6, 32'h4}) begin
            errors++;
            $display("FAIL stall_release: got busy=%h v=%b h=%0d pc=%h expected busy[1]=1 v=1 h=6 pc=4",
                     hart_busy, fetch_valid, fetch_hart, fetch_pc);
        end
        tick();
        checks++;
        if ({fetch_valid, hart_busy} !== {1'b0, 8'hFF}) begin
            errors++; $display("FAIL stall_drain: got v=%b busy=%h expected v=0 busy=ff", fetch_valid, hart_busy);
        end
    endtask

    task automatic test_misalign();
        set_commit(1'b1, 3'd4, 1'b1, 32'h0000_0200);
        tick();
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 3'd4, 32'h200}) begin
            errors++; $display("FAIL mis_setup: got v=%b h=%0d pc=%h expected v=1 h=4 pc=200", fetch_valid, fetch_hart, fetch_pc);
        end
        tick();
        set_commit(1'b1, 3'd4, 1'b1, 32'h0000_0102);
        tick();
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        checks++;
        if ({misalign_err, misalign_hart, misalign_pc} !== {1'b1, 3'd4, 32'h200}) begin
            errors++; $display("FAIL mis_pulse: got err=%b h=%0d pc=%h expected err=1 h=4 pc=200", misalign_err, misalign_hart, misalign_pc);
        end
        tick();
        checks++;
        if ({misalign_err, misalign_hart, misalign_pc} !== {1'b0, 3'd4, 32'h200}) begin
            errors++; $display("FAIL mis_hold: got err=%b h=%0d pc=%h expected err=0 h=4 pc=200", misalign_err, misalign_hart, misalign_pc);
        end
        tick(); tick();
        checks++;
        if ({fetch_valid, hart_busy[4]} !== 2'b00) begin
            errors++; $display("FAIL mis_halted: got v=%b busy=%h expected v=0 busy[4]=0", fetch_valid, hart_busy);
        end
        hart_en[4] = 1'b0;
        tick();
        hart_en[4] = 1'b1;
        tick(); tick();
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 3'd4, 32'h200}) begin
            errors++; $display("FAIL mis_restart: got v=%b h=%0d pc=%h expected v=1 h=4 pc=200", fetch_valid, fetch_hart, fetch_pc);
        end
        tick();
    endtask

    task automatic test_wrap();
        hart_en = 8'h01;
        set_commit(1'b1, 3'd0, 1'b1, 32'hFFFF_FFFC);
        tick();
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 3'd0, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL wrap_top: got v=%b h=%0d pc=%h expected v=1 h=0 pc=fffffffc", fetch_valid, fetch_hart, fetch_pc);
        end
        tick();
        set_commit(1'b1, 3'd0, 1'b0, 32'h0);
        tick();
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_not_same_cycle: got valid=%b expected 0", fetch_valid);
        end
        tick();
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 3'd0, 32'h0}) begin
            errors++; $display("FAIL wrap_zero: got v=%b h=%0d pc=%h expected v=1 h=0 pc=0", fetch_valid, fetch_hart, fetch_pc);
        end
        tick();
    endtask

    task automatic test_en_drop_wait();
        set_commit(1'b1, 3'd5, 1'b0, 32'h0);
        tick();
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        checks++;
        if (hart_busy !== 8'hDF) begin
            errors++; $display("FAIL endrop_busy: got busy=%h expected df", hart_busy);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (fetch_valid !== 1'b0) begin
                errors++; $display("FAIL endrop_nofetch%0d: got v=%b h=%0d expected v=0", k, fetch_valid, fetch_hart);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; tick();
        rst = 1'b0; hart_en = 8'hFF; fetch_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({fetch_valid, fetch_hart} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL rstmid_burst: got v=%b h=%0d expected v=1 h=1", fetch_valid, fetch_hart);
        end
        rst = 1'b1;
        set_commit(1'b1, 3'd0, 1'b1, 32'h0000_0300);
        tick();
        rst = 1'b0;
        set_commit(1'b0, 3'd0, 1'b0, 32'h0);
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc, misalign_err, misalign_hart, misalign_pc, hart_busy} !== 80'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got v=%b h=%0d pc=%h me=%b busy=%h expected all zero",
                     fetch_valid, fetch_hart, fetch_pc, misalign_err, hart_busy);
        end
        tick(); tick();
        checks++;
        if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 3'd0, 32'h0}) begin
            errors++; $display("FAIL rstmid_restart: got v=%b h=%0d pc=%h expected v=1 h=0 pc=0", fetch_valid, fetch_hart, fetch_pc);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_commit_update();
        test_stall();
        test_misalign();
        test_wrap();
        test_en_drop_wait();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
